uart_tx_buffered: RTL and testbench

//   Buffered 8N1 UART transmitter: host-side logic pushes bytes into an internal FIFO,
//   and the block serialises them on PinTX back-to-back with no idle gap between frames.
//   It is the dedicated transmit end of the camera UART link. It streams frame/RAM

---
 rtl/uart_tx_buffered.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes pushed into a small FIFO are serialised on PinTX
// back-to-back, CLKS_PER_BIT clocks per bit, with no idle gap between queued frames.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 50,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              PinTX,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } TxState;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic              pushOk;
    logic              popReq;
    logic [7:0]        headByte;

    TxState            state;
    TxState            stateNext;
    logic [BAUD_W-1:0] baudCnt;
    logic [BAUD_W-1:0] baudNext;
    logic [2:0]        bitIdx;
    logic [2:0]        bitNext;
    logic [7:0]        shiftReg;
    logic [7:0]        shiftNext;
    logic              txNext;
    logic              doneNext;

    // Flags come straight from the count register, so a push is judged on the
    // occupancy at the start of the cycle and a simultaneous pop cannot make room.
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign level    = count;
    assign busy     = (state != IDLE);
    assign pushOk   = wr_en && !full;
    assign headByte = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (pushOk) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (popReq) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            unique case ({pushOk, popReq})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            PinTX    <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            PinTX    <= txNext;
            tx_done  <= doneNext;
        end
    end

    // The line value is computed one cycle ahead so PinTX itself is a flop output.
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt + BAUD_W'(1);
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = PinTX;
        doneNext  = 1'b0;
        popReq    = 1'b0;

        unique case (state)
            IDLE: begin
                baudNext = '0;
                txNext   = 1'b1;
                if (!empty) begin
                    popReq    = 1'b1;
                    shiftNext = headByte;
                    txNext    = 1'b0;
                    stateNext = START;
                end
            end
            START: begin
                if (baudCnt == BAUD_LAST) begin
                    baudNext  = '0;
                    bitNext   = '0;
                    txNext    = shiftReg[0];
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (baudCnt == BAUD_LAST) begin
                    baudNext = '0;
                    if (bitIdx == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        shiftNext = {1'b0, shiftReg[7:1]};
                        txNext    = shiftReg[1];
                        bitNext   = bitIdx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baudCnt == BAUD_LAST) begin
                    baudNext = '0;
                    doneNext = 1'b1;
                    // Chaining straight into the next start bit keeps frames contiguous.
                    if (!empty) begin
                        popReq    = 1'b1;
                        shiftNext = headByte;
                        txNext    = 1'b0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: the line is compared against a waveform built
// from the queued bytes (start 0, LSB-first data, stop 1), plus occupancy and flag rules.
module tb_uart_tx_buffered;

    localparam int CPB    = 50;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int SCPB   = 4;
    localparam int SDEPTH = 4;
    localparam int SAW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wrEn;
    logic [7:0]    wrData;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          pinTx;
    logic          busy;
    logic          txDone;

    logic          sWrEn;
    logic [7:0]    sWrData;
    logic          sFull;
    logic          sEmpty;
    logic [SAW:0]  sLevel;
    logic          sOverflow;
    logic          sPinTx;
    logic          sBusy;
    logic          sTxDone;

    int            errors = 0;
    int            checks = 0;
    int            doneCnt;
    logic          lineQ[$];
    logic          expQ[$];
    logic [7:0]    byteQ[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_data(wrData),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .PinTX(pinTx), .busy(busy), .tx_done(txDone)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(SCPB), .FIFO_DEPTH(SDEPTH), .ADDR_W(SAW)) dutSmall (
        .clk(clk), .rst_n(rst_n), .wr_en(sWrEn), .wr_data(sWrData),
        .full(sFull), .empty(sEmpty), .level(sLevel), .overflow(sOverflow),
        .PinTX(sPinTx), .busy(sBusy), .tx_done(sTxDone)
    );

    // Expected line: one idle sample, each byte as 10 bits of cpb samples, then idle tail.
    task automatic buildWave(input int cpb, input int tail);
        expQ.delete();
        expQ.push_back(1'b1);
        foreach (byteQ[i]) begin
            for (int j = 0; j < 10; j++) begin
                logic v;
                v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : byteQ[i][j-1];
                repeat (cpb) expQ.push_back(v);
            end
        end
        repeat (tail) expQ.push_back(1'b1);
    endtask

    function automatic int waveDiff();
        int d = 0;
        if (lineQ.size() != expQ.size()) return 1000000;
        foreach (lineQ[i]) if (lineQ[i] !== expQ[i]) d++;
        return d;
    endfunction

    task automatic sampleBig();
        lineQ.push_back(pinTx);
        if (txDone) doneCnt++;
    endtask

    task automatic sampleSmall();
        lineQ.push_back(sPinTx);
        if (sTxDone) doneCnt++;
    endtask

    task automatic startScenario();
        lineQ.delete();
        byteQ.delete();
        doneCnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wrEn = 1'b0; wrData = '0; sWrEn = 1'b0; sWrData = '0;
        repeat (3) @(negedge clk);
        checks++; if (pinTx !== 1'b1) begin errors++; $display("[TB] FAIL reset_pintx: got %b want 1", pinTx); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
        checks++; if (level !== 0) begin errors++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
        checks++; if (busy !== 1'b0 || txDone !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got busy=%b done=%b ovf=%b want 0", busy, txDone, overflow); end
        checks++; if (sPinTx !== 1'b1 || sEmpty !== 1'b1) begin errors++; $display("[TB] FAIL reset_small: got tx=%b empty=%b want 1/1", sPinTx, sEmpty); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pinTx !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_idle: got tx=%b busy=%b want 1/0", pinTx, busy); end
    endtask

    task automatic test_single_byte();
        int busyBad = 0;
        startScenario();
        byteQ.push_back(8'hA5);
        for (int t = 0; t < 506; t++) begin
            wrEn = (t == 0); wrData = 8'hA5;
            @(negedge clk);
            sampleBig();
            if (t >= 1 && t <= 500 && busy !== 1'b1) busyBad++;
            if (t == 0) begin
                checks++; if (empty !== 1'b0 || level !== 1 || pinTx !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: got empty=%b level=%0d tx=%b want 0/1/1", empty, level, pinTx); end
            end
            if (t == 501) begin
                checks++; if (txDone !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done_time: got done=%b busy=%b want 1/0", txDone, busy); end
            end
        end
        buildWave(CPB, 5);
        checks++; if (waveDiff() != 0) begin errors++; $display("[TB] FAIL single_wave: got %0d wrong samples want 0", waveDiff()); end
        checks++; if (doneCnt != 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d want 1", doneCnt); end
        checks++; if (busyBad != 0) begin errors++; $display("[TB] FAIL single_busy: got %0d low cycles in frame want 0", busyBad); end
    endtask

    task automatic test_burst_overflow();
        startScenario();
        for (int i = 0; i < 17; i++) byteQ.push_back(8'(i));
        for (int t = 0; t < 8506; t++) begin
            wrEn = (t < 18); wrData = 8'(t);
            @(negedge clk);
            sampleBig();
            if (t == 16) begin
                checks++; if (full !== 1'b1 || level !== 16) begin errors++; $display("[TB] FAIL burst_full: got full=%b level=%0d want 1/16", full, level); end
            end
            if (t == 17) begin
                checks++; if (overflow !== 1'b1 || level !== 16) begin errors++; $display("[TB] FAIL burst_overflow: got ovf=%b level=%0d want 1/16", overflow, level); end
            end
            if (t == 18) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL burst_ovf_pulse: got %b want 0", overflow); end
            end
        end
        wrEn = 1'b0;
        buildWave(CPB, 5);
        checks++; if (waveDiff() != 0) begin errors++; $display("[TB] FAIL burst_wave: got %0d wrong samples want 0", waveDiff()); end
        checks++; if (doneCnt != 17) begin errors++; $display("[TB] FAIL burst_done_count: got %0d want 17", doneCnt); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL burst_drained: got empty=%b busy=%b want 1/0", empty, busy); end
    endtask

    task automatic test_overflow_at_pop();
        logic [7:0] extra;
        startScenario();
        for (int i = 0; i < 17; i++) byteQ.push_back(8'($urandom));
        extra = 8'($urandom);
        for (int t = 0; t < 8506; t++) begin
            wrEn = (t < 17) || (t == 501);
            wrData = (t < 17) ? byteQ[t] : extra;
            @(negedge clk);
            sampleBig();
            if (t == 500) begin
                checks++; if (full !== 1'b1 || level !== 16) begin errors++; $display("[TB] FAIL popovf_before: got full=%b level=%0d want 1/16", full, level); end
            end
            if (t == 501) begin
                checks++; if (overflow !== 1'b1 || level !== 15 || full !== 1'b0) begin errors++; $display("[TB] FAIL popovf_same_cycle: got ovf=%b level=%0d full=%b want 1/15/0", overflow, level, full); end
            end
        end
        wrEn = 1'b0;
        buildWave(CPB, 5);
        checks++; if (waveDiff() != 0) begin errors++; $display("[TB] FAIL popovf_wave: got %0d wrong samples want 0", waveDiff()); end
    endtask

    task automatic test_reset_midframe();
        int lows = 0;
        int busyHigh = 0;
        int levelBad = 0;
        startScenario();
        byteQ.push_back(8'h3C);
        for (int i = 0; i < 5; i++) byteQ.push_back(8'($urandom));
        for (int t = 0; t <= 220; t++) begin
            wrEn = (t < 6); wrData = (t < 6) ? byteQ[t] : 8'h00;
            @(negedge clk);
            if (t == 5) begin
                checks++; if (level !== 5) begin errors++; $display("[TB] FAIL midrst_queued: got %0d want 5", level); end
            end
            if (t == 219) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy); end
            end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (pinTx !== 1'b1 || level !== 0 || empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async: got tx=%b level=%0d empty=%b busy=%b want 1/0/1/0", pinTx, level, empty, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            sampleBig();
            if (pinTx !== 1'b1) lows++;
            if (busy !== 1'b0) busyHigh++;
            if (level !== 0) levelBad++;
        end
        checks++; if (lows != 0 || busyHigh != 0) begin errors++; $display("[TB] FAIL midrst_idle_after: got %0d low, %0d busy cycles want 0", lows, busyHigh); end
        checks++; if (doneCnt != 0 || levelBad != 0) begin errors++; $display("[TB] FAIL midrst_no_done: got done=%0d levelBad=%0d want 0", doneCnt, levelBad); end
    endtask

    task automatic test_small_wrap();
        for (int b = 0; b < 5; b++) begin
            int n;
            int expLevel;
            startScenario();
            if (b == 0) begin
                byteQ.push_back(8'hFF);
                byteQ.push_back(8'h00);
            end else begin
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) byteQ.push_back(8'($urandom));
            end
            n = byteQ.size();
            expLevel = (n == 1) ? 1 : n - 1;
            for (int t = 0; t < 1 + n * 40 + 4; t++) begin
                sWrEn = (t < n); sWrData = (t < n) ? byteQ[t] : 8'h00;
                @(negedge clk);
                sampleSmall();
                if (t == n - 1) begin
                    checks++; if (sLevel !== expLevel) begin errors++; $display("[TB] FAIL small_level_b%0d: got %0d want %0d", b, sLevel, expLevel); end
                end
            end
            sWrEn = 1'b0;
            buildWave(SCPB, 4);
            checks++; if (waveDiff() != 0) begin errors++; $display("[TB] FAIL small_wave_b%0d: got %0d wrong samples want 0", b, waveDiff()); end
            checks++; if (doneCnt != n || sEmpty !== 1'b1) begin errors++; $display("[TB] FAIL small_done_b%0d: got done=%0d empty=%b want %0d/1", b, doneCnt, sEmpty, n); end
        end
    endtask

    task automatic test_steady_state();
        int ovfCnt = 0;
        int flagBad = 0;
        int levelBad = 0;
        startScenario();
        for (int i = 0; i < 6; i++) byteQ.push_back(8'($urandom));
        for (int t = 0; t < 3006; t++) begin
            int expLevel;
            wrEn = (t % 500 == 0) && (t / 500 < 6);
            wrData = (t / 500 < 6) ? byteQ[t / 500] : 8'h00;
            @(negedge clk);
            sampleBig();
            expLevel = ((t % 500 == 0) && (t / 500 < 6)) ? 1 : 0;
            if (overflow !== 1'b0) ovfCnt++;
            if (full !== 1'b0 || empty !== (level == 0)) flagBad++;
            if (level !== expLevel) levelBad++;
        end
        wrEn = 1'b0;
        buildWave(CPB, 5);
        checks++; if (waveDiff() != 0) begin errors++; $display("[TB] FAIL steady_wave: got %0d wrong samples want 0", waveDiff()); end
        checks++; if (ovfCnt != 0 || flagBad != 0) begin errors++; $display("[TB] FAIL steady_flags: got ovf=%0d flagBad=%0d want 0", ovfCnt, flagBad); end
        checks++; if (levelBad != 0) begin errors++; $display("[TB] FAIL steady_level: got %0d wrong cycles want 0", levelBad); end
        checks++; if (doneCnt != 6) begin errors++; $display("[TB] FAIL steady_done_count: got %0d want 6", doneCnt); end
    endtask

    initial begin
        test_reset();
        $display("[TB] reset done");
        test_single_byte();
        repeat (3) @(negedge clk);
        test_burst_overflow();
        repeat (3) @(negedge clk);
        test_overflow_at_pop();
        repeat (3) @(negedge clk);
        test_reset_midframe();
        repeat (3) @(negedge clk);
        test_small_wrap();
        repeat (3) @(negedge clk);
        test_steady_state();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
